id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Decode/operand-fetch stage of the multi-cycle CPU; sits directly upstream of the ALU/execute stage.
- Accepts one instruction at a time from fetch and drives both regfile read addresses.
- Captures the asynchronously read operands and presents a decoded bundle to execute over a valid/ready handshake.
- Tracks one outstanding destination register and stalls on a read-after-write hazard until write-back commits.

Parameters:
- RA_REG, 31, link register index written by jal.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_inst  in  32  instruction word.
- if_pc  in  32  instruction PC.
- id_ready  out  1  stage can accept from fetch.
- rf_raddr1  out  5  regfile read port 1 address (rs).
- rf_raddr2  out  5  regfile read port 2 address (rt).
- rf_rdata1  in  32  regfile read port 1 data (combinational, same cycle).
- rf_rdata2  in  32  regfile read port 2 data.
- wb_wen  in  1  regfile write enable this cycle.
- wb_waddr  in  5  regfile write address this cycle.
- ex_valid  out  1  decoded bundle valid.
- ex_ready  in  1  execute accepts bundle.
- ex_pc  out  32  latched PC.
- ex_opcode  out  6  inst[31:26].
- ex_funct  out  6  inst[5:0].
- ex_shamt  out  5  inst[10:6].
- ex_src_a  out  32  captured rs value.
- ex_src_b  out  32  captured rt value.
- ex_imm  out  32  extended immediate.
- ex_dest  out  5  destination register, 0 = none.
- ex_wb_en  out  1  ex_dest != 0.
- ex_target  out  26  inst[25:0].

Behaviour:
- Reset (async): state IDLE; id_ready=1; ex_valid=0; all ex_* data, pending_valid and pending_dest cleared to 0; rf_raddr1/2 = 0.
- Latched registers inst_q and pc_q load only on an accepted fetch handshake.
- rf_raddr1 = inst_q[25:21], rf_raddr2 = inst_q[20:16] in every state except IDLE, where both are 0.
- Decode is combinational from inst_q:
  - dest: op 0x00 → rd; op 0x03 → RA_REG; op 0x08–0x0F or 0x23 → rt; all other opcodes → 0.
  - imm: op 0x0C/0x0D/0x0E → zero-extended; op 0x0F → {imm16, 16'h0}; otherwise sign-extended.
  - uses_rs: op not in {0x02, 0x03, 0x0F}.
  - uses_rt: op in {0x00, 0x2B, 0x04, 0x05}.
- Hazard is true when all of the following hold:
  - pending_valid;
  - pending_dest != 0;
  - (uses_rs && rs == pending_dest) || (uses_rt && rt == pending_dest).
- FSM:
  - IDLE: id_ready=1. if_valid → latch inst/pc, go READ.
  - READ: if hazard → go HOLD. Else capture rf_rdata1/2 into ex_src_a/b, register the decode outputs into ex_*, set ex_valid, go OUT.
  - HOLD: stay until pending_valid clears, then go READ. The regfile write lands at that edge, so READ samples the new value.
  - OUT: ex_valid=1 with ex_* stable. On ex_ready: drop ex_valid; load pending_dest=ex_dest and pending_valid=ex_wb_en; go IDLE.
- Minimum latency is 3 cycles: accept, READ capture, then OUT presents ex_valid. The same cycle's ex_ready completes the transfer.
- Pending clear: any cycle with wb_wen && wb_waddr == pending_dest clears pending_valid, in any state.
- Simultaneous clear and OUT handshake: the new set wins, so pending takes the new instruction's dest.
- Register 0: dest 0 never sets pending, and rs/rt == 0 never hazards.
- wb writes to non-pending registers are ignored.
- Reset mid-operation: all state returns to IDLE and any in-flight instruction is discarded; no ex_valid pulse follows deassertion.
- id_ready is 0 in READ, HOLD and OUT. Fetch holds if_inst until accepted.

Test Plan:
1. Reset then addu $3,$1,$2 (0x00221821) with regfile $1=5, $2=7 → 3 cycles later ex_valid=1, src_a=5, src_b=7, dest=3, wb_en=1, imm=0x00001821.
2. ori $4,$0,0x8001 → imm=0x00008001 (zero-extended); addiu $4,$0,0x8001 → imm=0xFFFF8001; lui → imm=0x80010000; dest=4.
3. Hazard:
   - addu $3 accepted by execute, then subu $5,$3,$1 → FSM in HOLD, ex_valid=0.
   - Pulse wb_wen with waddr=3 and wdata=0x1234 → next cycle READ captures src_a=0x1234, then ex_valid.
4. sw $3,4($2) while $3 is pending → stall (uses_rt). j 0x100 while $3 is pending → no stall, dest=0, wb_en=0.
5. Hold ex_ready=0 for 5 cycles in OUT → ex_* stable, id_ready=0. The wb match for pending arriving in the same cycle as the handshake → pending = new dest.
6. Assert resetn=0 while in HOLD → immediate ex_valid=0, pending_valid=0, id_ready=1, raddrs=0.

Source files
------------

// File: rtl/id_operand_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode/operand-fetch stage.
// The stage is the slave: it consumes fetch traffic and is steered by execute's ready.
interface id_operand_stage_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_src_a;
  logic [31:0] ex_src_b;
  logic [31:0] ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_wb_en;
  logic [25:0] ex_target;

  modport master (
    output if_valid, if_inst, if_pc, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
           ex_src_a, ex_src_b, ex_imm, ex_dest, ex_wb_en, ex_target
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_opcode, ex_funct, ex_shamt,
           ex_src_a, ex_src_b, ex_imm, ex_dest, ex_wb_en, ex_target
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: latches one instruction, reads the regfile, and hands a
// decoded bundle to execute while stalling on a read-after-write hazard with write-back.
module id_operand_stage #(
  parameter int unsigned RA_REG = 31
) (
  input  logic              clk,
  input  logic              resetn,
  id_operand_stage_if.slave bus,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              wb_wen,
  input  logic [4:0]        wb_waddr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [4:0] RA5 = 5'(RA_REG);

  function automatic logic [4:0] dec_dest(input logic [31:0] inst);
    logic [4:0] d;
    case (inst[31:26])
      6'h00:                      d = inst[15:11];
      6'h03:                      d = RA5;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23:                      d = inst[20:16];
      default:                    d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] dec_imm(input logic [31:0] inst);
    logic [31:0] v;
    case (inst[31:26])
      6'h0C, 6'h0D, 6'h0E: v = {16'h0000, inst[15:0]};
      6'h0F:               v = {inst[15:0], 16'h0000};
      default:             v = {{16{inst[15]}}, inst[15:0]};
    endcase
    return v;
  endfunction

  function automatic logic dec_uses_rs(input logic [5:0] op);
    return !(op inside {6'h02, 6'h03, 6'h0F});
  endfunction

  function automatic logic dec_uses_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04, 6'h05};
  endfunction

  state_t      state;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        pending_valid;
  logic [4:0]  pending_dest;

  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  logic [5:0]  ex_opcode_q;
  logic [5:0]  ex_funct_q;
  logic [4:0]  ex_shamt_q;
  logic [31:0] ex_src_a_q;
  logic [31:0] ex_src_b_q;
  logic [31:0] ex_imm_q;
  logic [4:0]  ex_dest_q;
  logic        ex_wb_en_q;
  logic [25:0] ex_target_q;

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  dest_d;
  logic [31:0] imm_d;
  logic        hazard;
  logic        clear_hit;

  assign rs        = inst_q[25:21];
  assign rt        = inst_q[20:16];
  assign dest_d    = dec_dest(inst_q);
  assign imm_d     = dec_imm(inst_q);
  assign hazard    = pending_valid && (pending_dest != 5'd0) &&
                     ((dec_uses_rs(inst_q[31:26]) && (rs == pending_dest)) ||
                      (dec_uses_rt(inst_q[31:26]) && (rt == pending_dest)));
  assign clear_hit = wb_wen && (wb_waddr == pending_dest);

  assign rf_raddr1 = (state == IDLE) ? 5'd0 : rs;
  assign rf_raddr2 = (state == IDLE) ? 5'd0 : rt;

  assign bus.id_ready  = (state == IDLE);
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_opcode = ex_opcode_q;
  assign bus.ex_funct  = ex_funct_q;
  assign bus.ex_shamt  = ex_shamt_q;
  assign bus.ex_src_a  = ex_src_a_q;
  assign bus.ex_src_b  = ex_src_b_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_dest   = ex_dest_q;
  assign bus.ex_wb_en  = ex_wb_en_q;
  assign bus.ex_target = ex_target_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      inst_q        <= '0;
      pc_q          <= '0;
      pending_valid <= 1'b0;
      pending_dest  <= '0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct_q    <= '0;
      ex_shamt_q    <= '0;
      ex_src_a_q    <= '0;
      ex_src_b_q    <= '0;
      ex_imm_q      <= '0;
      ex_dest_q     <= '0;
      ex_wb_en_q    <= 1'b0;
      ex_target_q   <= '0;
    end else begin
      // Write-back clear first so an OUT handshake in the same cycle overrides it.
      if (clear_hit) pending_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.if_valid) begin
            inst_q <= bus.if_inst;
            pc_q   <= bus.if_pc;
            state  <= READ;
          end
        end
        READ: begin
          if (hazard) begin
            state <= HOLD;
          end else begin
            ex_pc_q     <= pc_q;
            ex_opcode_q <= inst_q[31:26];
            ex_funct_q  <= inst_q[5:0];
            ex_shamt_q  <= inst_q[10:6];
            ex_src_a_q  <= rf_rdata1;
            ex_src_b_q  <= rf_rdata2;
            ex_imm_q    <= imm_d;
            ex_dest_q   <= dest_d;
            ex_wb_en_q  <= (dest_d != 5'd0);
            ex_target_q <= inst_q[25:0];
            ex_valid_q  <= 1'b1;
            state       <= OUT;
          end
        end
        HOLD: begin
          // The clearing write lands at this edge, so READ sees the fresh value.
          if (!pending_valid || clear_hit) state <= READ;
        end
        OUT: begin
          if (bus.ex_ready) begin
            ex_valid_q    <= 1'b0;
            pending_dest  <= ex_dest_q;
            pending_valid <= ex_wb_en_q;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a small behavioural regfile and hand-computed vectors.
module tb_id_operand_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] regs [32] = '{default: 32'h0};

  int total  = 0;
  int passed = 0;

  id_operand_stage_if bus ();

  id_operand_stage #(.RA_REG(31)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'h0 : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'h0 : regs[rf_raddr2];

  always @(posedge clk) begin
    if (wb_wen && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    chk("id_ready_before_issue", {31'b0, bus.id_ready}, 32'd1);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    step();
    bus.if_valid = 1'b0;
  endtask

  // Called in the READ cycle of a non-stalling instruction.
  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] dest, input logic [31:0] imm);
    chk({tag, "_vld_read"}, {31'b0, bus.ex_valid}, 32'd0);
    step();
    chk({tag, "_vld"},   {31'b0, bus.ex_valid}, 32'd1);
    chk({tag, "_src_a"}, bus.ex_src_a, a);
    chk({tag, "_src_b"}, bus.ex_src_b, b);
    chk({tag, "_dest"},  {27'b0, bus.ex_dest}, {27'b0, dest});
    chk({tag, "_wb_en"}, {31'b0, bus.ex_wb_en}, {31'b0, dest != 5'd0});
    chk({tag, "_imm"},   bus.ex_imm, imm);
    chk({tag, "_rdy0"},  {31'b0, bus.id_ready}, 32'd0);
  endtask

  task automatic accept();
    bus.ex_ready = 1'b1;
    step();
    bus.ex_ready = 1'b0;
    chk("accept_vld_drop", {31'b0, bus.ex_valid}, 32'd0);
    chk("accept_idle",     {31'b0, bus.id_ready}, 32'd1);
  endtask

  task automatic wb_pulse(input logic [4:0] a, input logic [31:0] d);
    wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
    step();
    wb_wen = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    step(); step();
    chk("rst_id_ready", {31'b0, bus.id_ready}, 32'd1);
    chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_raddr1",   {27'b0, rf_raddr1}, 32'd0);
    chk("rst_raddr2",   {27'b0, rf_raddr2}, 32'd0);
    chk("rst_src_a",    bus.ex_src_a, 32'd0);
    chk("rst_dest",     {27'b0, bus.ex_dest}, 32'd0);
    resetn = 1'b1;
    wb_pulse(5'd1, 32'd5);
    wb_pulse(5'd2, 32'd7);

    // addu $3,$1,$2
    issue(32'h00221821, 32'h0000_1000);
    chk("addu_raddr1", {27'b0, rf_raddr1}, 32'd1);
    chk("addu_raddr2", {27'b0, rf_raddr2}, 32'd2);
    expect_out("addu", 32'd5, 32'd7, 5'd3, 32'h0000_1821);
    chk("addu_funct",  {26'b0, bus.ex_funct}, 32'h21);
    chk("addu_opcode", {26'b0, bus.ex_opcode}, 32'h0);
    chk("addu_pc",     bus.ex_pc, 32'h0000_1000);
    accept();

    // Immediate extension variants, all with rs=$0
    issue(32'h34048001, 32'h0000_1004);
    expect_out("ori", 32'd0, 32'd0, 5'd4, 32'h0000_8001);
    accept();
    issue(32'h24048001, 32'h0000_1008);
    expect_out("addiu", 32'd0, 32'd0, 5'd4, 32'hFFFF_8001);
    accept();
    issue(32'h3C048001, 32'h0000_100C);
    expect_out("lui", 32'd0, 32'd0, 5'd4, 32'h8001_0000);
    accept();

    // RAW on rs: subu $5,$3,$1 after addu $3
    issue(32'h00221821, 32'h0000_1010);
    expect_out("addu2", 32'd5, 32'd7, 5'd3, 32'h0000_1821);
    accept();
    issue(32'h00612823, 32'h0000_1014);
    step(); step(); step();
    chk("subu_hold_vld",  {31'b0, bus.ex_valid}, 32'd0);
    chk("subu_hold_rdy",  {31'b0, bus.id_ready}, 32'd0);
    chk("subu_hold_ra1",  {27'b0, rf_raddr1}, 32'd3);
    wb_pulse(5'd3, 32'h0000_1234);
    expect_out("subu", 32'h0000_1234, 32'd5, 5'd5, 32'h0000_2823);
    accept();

    // RAW on rt: sw $3,4($2)
    issue(32'h00221821, 32'h0000_1018);
    expect_out("addu3", 32'd5, 32'd7, 5'd3, 32'h0000_1821);
    accept();
    issue(32'hAC430004, 32'h0000_101C);
    step(); step(); step();
    chk("sw_hold_vld", {31'b0, bus.ex_valid}, 32'd0);
    wb_pulse(5'd3, 32'h0000_0055);
    expect_out("sw", 32'd7, 32'h0000_0055, 5'd0, 32'h0000_0004);
    accept();

    // j never stalls, even with $3 pending
    issue(32'h00221821, 32'h0000_1020);
    expect_out("addu4", 32'd5, 32'd7, 5'd3, 32'h0000_1821);
    accept();
    issue(32'h08000100, 32'h0000_1024);
    expect_out("j", 32'd0, 32'd0, 5'd0, 32'h0000_0100);
    chk("j_target", {6'b0, bus.ex_target}, 32'h0000_0100);
    accept();

    // Backpressure: bundle held stable for 5 cycles
    issue(32'h00221821, 32'h0000_1028);
    expect_out("addu5", 32'd5, 32'd7, 5'd3, 32'h0000_1821);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld",   {31'b0, bus.ex_valid}, 32'd1);
      chk("bp_src_a", bus.ex_src_a, 32'd5);
      chk("bp_dest",  {27'b0, bus.ex_dest}, 32'd3);
      chk("bp_rdy",   {31'b0, bus.id_ready}, 32'd0);
    end
    accept();

    // Clear of $3 coincides with handshake of addu $6: pending becomes $6
    issue(32'h00223021, 32'h0000_102C);
    expect_out("addu6", 32'd5, 32'd7, 5'd6, 32'h0000_3021);
    bus.ex_ready = 1'b1;
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_0077;
    step();
    bus.ex_ready = 1'b0; wb_wen = 1'b0;
    issue(32'h00C13823, 32'h0000_1030);
    step(); step(); step();
    chk("sim_hold_vld", {31'b0, bus.ex_valid}, 32'd0);
    chk("sim_hold_rdy", {31'b0, bus.id_ready}, 32'd0);

    // Async reset while in HOLD
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_vld",  {31'b0, bus.ex_valid}, 32'd0);
    chk("mid_rst_rdy",  {31'b0, bus.id_ready}, 32'd1);
    chk("mid_rst_ra1",  {27'b0, rf_raddr1}, 32'd0);
    chk("mid_rst_ra2",  {27'b0, rf_raddr2}, 32'd0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_vld", {31'b0, bus.ex_valid}, 32'd0);
    end
    // Pending was wiped, so subu $7,$6,$1 issues without stalling
    issue(32'h00C13823, 32'h0000_1034);
    expect_out("post_rst_subu", 32'd0, 32'd5, 5'd7, 32'h0000_3823);
    accept();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
